// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one peripheral/memory bus between two requesters (port 0 = CPU data
// access, port 1 = DMA/debug loader). A granted request is copied into holding
// registers, presented on the bus for WAIT_STATES+1 ACCESS cycles, and then
// acknowledged with a one-cycle done pulse on the owning port. Read data is
// captured on the last ACCESS edge and retained until that port's next read.
//
// Build option:
//   ARB_PORT0_PRIORITY_EN  defined   -> port 0 always wins simultaneous requests
//                          undefined -> round-robin (last_grant starts at 1)
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   rN_req/write/address/wdata   request side of port N (held until rN_done)
//   rN_rdata, rN_done     read data (valid with done) and completion pulse
//   mem_address/wdata     bus address and write data (from holding registers)
//   mem_read/mem_write    bus strobes, high for every ACCESS cycle
//   mem_rdata             bus read data
//   grant                 index of the port owning the bus (held in IDLE)
//   busy                  high while in ACCESS or DONE
// All outputs are registered.
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  r0_req,
  input  logic                  r0_write,
  input  logic [ADDR_WIDTH-1:0] r0_address,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  output logic                  r0_done,
  input  logic                  r1_req,
  input  logic                  r1_write,
  input  logic [ADDR_WIDTH-1:0] r1_address,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  r1_done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  grant,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Counter value on the final ACCESS cycle.
  localparam logic [3:0] LAST_COUNT = 4'(WAIT_STATES);

  state_t                state_r;
  state_t                state_nxt_s;
  logic [3:0]            count_r;
  logic                  any_req_s;
  logic                  start_s;
  logic                  access_last_s;
  logic                  winner_s;

  logic                  grant_r;
  logic                  write_hold_r;
  logic [ADDR_WIDTH-1:0] addr_hold_r;
  logic [DATA_WIDTH-1:0] wdata_hold_r;

  logic                  write_sel_s;
  logic                  grant_nxt_s;
  logic                  mem_read_nxt_s;
  logic                  mem_write_nxt_s;
  logic                  r0_done_nxt_s;
  logic                  r1_done_nxt_s;
  logic                  busy_nxt_s;

  logic                  mem_read_r;
  logic                  mem_write_r;
  logic                  r0_done_r;
  logic                  r1_done_r;
  logic                  busy_r;
  logic [DATA_WIDTH-1:0] r0_rdata_r;
  logic [DATA_WIDTH-1:0] r1_rdata_r;

  assign any_req_s     = r0_req | r1_req;
  assign start_s       = (state_r == ST_IDLE) & any_req_s;
  assign access_last_s = (state_r == ST_ACCESS) & (count_r == LAST_COUNT);

`ifdef ARB_PORT0_PRIORITY_EN
  // Fixed priority: port 0 wins whenever it requests; port 1 may starve.
  always_comb begin
    winner_s = 1'b0;
    if (r0_req) begin
      winner_s = 1'b0;
    end else if (r1_req) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
  end
`else
  logic last_grant_r;

  // Round-robin: on contention the port that did not win last time goes next.
  always_comb begin
    winner_s = 1'b0;
    if (r0_req && r1_req) begin
      winner_s = ~last_grant_r;
    end else if (r1_req) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
  end

  // Remember the most recent winner; reset value makes port 0 win the first tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_r <= 1'b1;
    end else if (start_s) begin
      last_grant_r <= winner_s;
    end
  end
`endif

  // State register and ACCESS cycle counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      count_r <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == ST_ACCESS) && !access_last_s) begin
        count_r <= count_r + 4'd1;
      end else begin
        count_r <= 4'd0;
      end
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_nxt_s = ST_ACCESS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (access_last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the state being entered.
  always_comb begin
    write_sel_s     = write_hold_r;
    grant_nxt_s     = grant_r;
    mem_read_nxt_s  = 1'b0;
    mem_write_nxt_s = 1'b0;
    r0_done_nxt_s   = 1'b0;
    r1_done_nxt_s   = 1'b0;
    busy_nxt_s      = 1'b0;
    // The strobe type for the first ACCESS cycle comes from the winner's input,
    // later cycles from the holding register.
    if (start_s) begin
      write_sel_s = winner_s ? r1_write : r0_write;
      grant_nxt_s = winner_s;
    end else begin
      write_sel_s = write_hold_r;
      grant_nxt_s = grant_r;
    end
    mem_read_nxt_s  = (state_nxt_s == ST_ACCESS) & ~write_sel_s;
    mem_write_nxt_s = (state_nxt_s == ST_ACCESS) & write_sel_s;
    r0_done_nxt_s   = (state_nxt_s == ST_DONE) & ~grant_r;
    r1_done_nxt_s   = (state_nxt_s == ST_DONE) & grant_r;
    busy_nxt_s      = (state_nxt_s != ST_IDLE);
  end

  // Holding registers and grant: captured once at grant time so later input
  // changes never reach the bus.
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_r      <= 1'b0;
      write_hold_r <= 1'b0;
      addr_hold_r  <= '0;
      wdata_hold_r <= '0;
    end else if (start_s) begin
      grant_r      <= grant_nxt_s;
      write_hold_r <= write_sel_s;
      addr_hold_r  <= winner_s ? r1_address : r0_address;
      wdata_hold_r <= winner_s ? r1_wdata : r0_wdata;
    end
  end

  // Output registers, including read-data capture on the last ACCESS edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      r0_done_r   <= 1'b0;
      r1_done_r   <= 1'b0;
      busy_r      <= 1'b0;
      r0_rdata_r  <= '0;
      r1_rdata_r  <= '0;
    end else begin
      mem_read_r  <= mem_read_nxt_s;
      mem_write_r <= mem_write_nxt_s;
      r0_done_r   <= r0_done_nxt_s;
      r1_done_r   <= r1_done_nxt_s;
      busy_r      <= busy_nxt_s;
      if (access_last_s && !write_hold_r) begin
        if (grant_r) begin
          r1_rdata_r <= mem_rdata;
        end else begin
          r0_rdata_r <= mem_rdata;
        end
      end
    end
  end

  assign mem_address = addr_hold_r;
  assign mem_wdata   = wdata_hold_r;
  assign mem_read    = mem_read_r;
  assign mem_write   = mem_write_r;
  assign r0_done     = r0_done_r;
  assign r1_done     = r1_done_r;
  assign r0_rdata    = r0_rdata_r;
  assign r1_rdata    = r1_rdata_r;
  assign grant       = grant_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for mem_bus_arbiter. Instance u0 uses WAIT_STATES=2, instance u1
// uses WAIT_STATES=0; both share the same request/bus-input stimulus.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int WS  = 2;
  localparam int WS0 = 0;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          r0_req = 1'b0, r0_write = 1'b0, r1_req = 1'b0, r1_write = 1'b0;
  logic [AW-1:0] r0_address = '0, r1_address = '0;
  logic [DW-1:0] r0_wdata = '0, r1_wdata = '0, mem_rdata = '0;

  logic [DW-1:0] a_r0_rdata, a_r1_rdata, a_mem_wdata, b_r0_rdata, b_r1_rdata, b_mem_wdata;
  logic [AW-1:0] a_mem_address, b_mem_address;
  logic          a_r0_done, a_r1_done, a_mem_read, a_mem_write, a_grant, a_busy;
  logic          b_r0_done, b_r1_done, b_mem_read, b_mem_write, b_grant, b_busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(WS)) u0 (
    .clock(clock), .reset(reset),
    .r0_req(r0_req), .r0_write(r0_write), .r0_address(r0_address), .r0_wdata(r0_wdata),
    .r0_rdata(a_r0_rdata), .r0_done(a_r0_done),
    .r1_req(r1_req), .r1_write(r1_write), .r1_address(r1_address), .r1_wdata(r1_wdata),
    .r1_rdata(a_r1_rdata), .r1_done(a_r1_done),
    .mem_address(a_mem_address), .mem_wdata(a_mem_wdata), .mem_read(a_mem_read),
    .mem_write(a_mem_write), .mem_rdata(mem_rdata), .grant(a_grant), .busy(a_busy));

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(WS0)) u1 (
    .clock(clock), .reset(reset),
    .r0_req(r0_req), .r0_write(r0_write), .r0_address(r0_address), .r0_wdata(r0_wdata),
    .r0_rdata(b_r0_rdata), .r0_done(b_r0_done),
    .r1_req(r1_req), .r1_write(r1_write), .r1_address(r1_address), .r1_wdata(r1_wdata),
    .r1_rdata(b_r1_rdata), .r1_done(b_r1_done),
    .mem_address(b_mem_address), .mem_wdata(b_mem_wdata), .mem_read(b_mem_read),
    .mem_write(b_mem_write), .mem_rdata(mem_rdata), .grant(b_grant), .busy(b_busy));

  // ---------------- transaction-timeline reference model (for u0) ----------
  int            m_cyc = 0, m_gedge = -1000, m_free = 0;
  logic          m_owner = 1'b0, m_last = 1'b1, m_write = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0, exp_rdata0 = '0, exp_rdata1 = '0;
  logic          exp_rd = 1'b0, exp_wr = 1'b0, exp_done0 = 1'b0, exp_done1 = 1'b0, exp_busy = 1'b0;

  // Called just after each rising edge; predicts outputs for the cycle that follows.
  task automatic model_step();
    int  k;
    bit  in_acc, in_done;
    m_cyc++;
    if (reset) begin
      m_gedge = -1000; m_free = m_cyc + 1; m_owner = 1'b0; m_last = 1'b1; m_write = 1'b0;
      exp_addr = '0; exp_wdata = '0; exp_rdata0 = '0; exp_rdata1 = '0;
      exp_rd = 1'b0; exp_wr = 1'b0; exp_done0 = 1'b0; exp_done1 = 1'b0; exp_busy = 1'b0;
    end else begin
      if (m_cyc >= m_free && (r0_req || r1_req)) begin
`ifdef ARB_PORT0_PRIORITY_EN
        m_owner = r0_req ? 1'b0 : 1'b1;
`else
        if (r0_req && r1_req) m_owner = ~m_last;
        else m_owner = r1_req;
`endif
        m_last    = m_owner;
        m_write   = m_owner ? r1_write : r0_write;
        exp_addr  = m_owner ? r1_address : r0_address;
        exp_wdata = m_owner ? r1_wdata : r0_wdata;
        m_gedge   = m_cyc;
        m_free    = m_cyc + WS + 3;
      end
      k       = m_cyc - m_gedge + 1;
      in_acc  = (k >= 1) && (k <= WS + 1);
      in_done = (k == WS + 2);
      exp_rd    = in_acc && !m_write;
      exp_wr    = in_acc && m_write;
      exp_done0 = in_done && !m_owner;
      exp_done1 = in_done && m_owner;
      exp_busy  = in_acc || in_done;
      if (in_done && !m_write) begin
        if (m_owner) exp_rdata1 = mem_rdata;
        else exp_rdata0 = mem_rdata;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; r0_req = 1'b0; r1_req = 1'b0;
    @(posedge clock); @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clock); @(posedge clock);
    @(negedge clock);
    n_cmp++; if (a_mem_address !== 32'h0) begin n_bad++; $display("FAIL reset.mem_address got %0h want 0", a_mem_address); end
    n_cmp++; if (a_mem_wdata !== 64'h0) begin n_bad++; $display("FAIL reset.mem_wdata got %0h want 0", a_mem_wdata); end
    n_cmp++; if ({a_mem_read, a_mem_write} !== 2'b00) begin n_bad++; $display("FAIL reset.strobes got %b want 00", {a_mem_read, a_mem_write}); end
    n_cmp++; if ({a_r0_done, a_r1_done} !== 2'b00) begin n_bad++; $display("FAIL reset.done got %b want 00", {a_r0_done, a_r1_done}); end
    n_cmp++; if (a_r0_rdata !== 64'h0 || a_r1_rdata !== 64'h0) begin n_bad++; $display("FAIL reset.rdata got %0h/%0h want 0/0", a_r0_rdata, a_r1_rdata); end
    n_cmp++; if ({a_grant, a_busy} !== 2'b00) begin n_bad++; $display("FAIL reset.grant_busy got %b want 00", {a_grant, a_busy}); end
    n_cmp++; if ({b_mem_read, b_mem_write, b_r0_done, b_r1_done, b_grant, b_busy, b_r0_rdata, b_r1_rdata, b_mem_address} !== '0) begin
      n_bad++; $display("FAIL reset.u1_outputs got nonzero want 0"); end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    logic exp;
    r0_req = 1'b1; r0_write = 1'b0; r0_address = 32'h10; mem_rdata = 64'hDEAD_BEEF_0000_0001;
    for (int k = 1; k <= WS + 3; k++) begin
      @(negedge clock);
      exp = (k <= WS + 1);
      n_cmp++; if (a_mem_read !== exp) begin n_bad++; $display("FAIL read.mem_read k=%0d got %b want %b", k, a_mem_read, exp); end
      n_cmp++; if (a_mem_write !== 1'b0) begin n_bad++; $display("FAIL read.mem_write k=%0d got %b want 0", k, a_mem_write); end
      exp = (k == WS + 2);
      n_cmp++; if (a_r0_done !== exp) begin n_bad++; $display("FAIL read.r0_done k=%0d got %b want %b", k, a_r0_done, exp); end
      exp = (k <= WS + 2);
      n_cmp++; if (a_busy !== exp) begin n_bad++; $display("FAIL read.busy k=%0d got %b want %b", k, a_busy, exp); end
      if (k <= WS + 2) begin
        n_cmp++; if (a_mem_address !== 32'h10) begin n_bad++; $display("FAIL read.mem_address k=%0d got %0h want 10", k, a_mem_address); end
        n_cmp++; if (a_grant !== 1'b0) begin n_bad++; $display("FAIL read.grant k=%0d got %b want 0", k, a_grant); end
      end
      if (k >= WS + 2) begin
        n_cmp++; if (a_r0_rdata !== 64'hDEAD_BEEF_0000_0001) begin n_bad++; $display("FAIL read.r0_rdata k=%0d got %0h want deadbeef00000001", k, a_r0_rdata); end
      end
      if (k == WS + 2) r0_req = 1'b0;
    end
  endtask

  task automatic test_single_write();
    logic exp;
    r1_req = 1'b1; r1_write = 1'b1; r1_address = 32'h20; r1_wdata = 64'h1234; mem_rdata = 64'h5555;
    for (int k = 1; k <= WS + 3; k++) begin
      @(negedge clock);
      exp = (k <= WS + 1);
      n_cmp++; if (a_mem_write !== exp) begin n_bad++; $display("FAIL write.mem_write k=%0d got %b want %b", k, a_mem_write, exp); end
      n_cmp++; if (a_mem_read !== 1'b0) begin n_bad++; $display("FAIL write.mem_read k=%0d got %b want 0", k, a_mem_read); end
      exp = (k == WS + 2);
      n_cmp++; if (a_r1_done !== exp) begin n_bad++; $display("FAIL write.r1_done k=%0d got %b want %b", k, a_r1_done, exp); end
      if (k <= WS + 2) begin
        n_cmp++; if (a_mem_wdata !== 64'h1234 || a_mem_address !== 32'h20) begin
          n_bad++; $display("FAIL write.bus k=%0d got %0h@%0h want 1234@20", k, a_mem_wdata, a_mem_address); end
        n_cmp++; if (a_grant !== 1'b1) begin n_bad++; $display("FAIL write.grant k=%0d got %b want 1", k, a_grant); end
      end
      n_cmp++; if (a_r1_rdata !== 64'h0 || a_r0_rdata !== 64'hDEAD_BEEF_0000_0001) begin
        n_bad++; $display("FAIL write.rdata_kept k=%0d got %0h/%0h want deadbeef00000001/0", k, a_r0_rdata, a_r1_rdata); end
      if (k == WS + 2) r1_req = 1'b0;
    end
  endtask

  task automatic test_contention();
    logic [3:0] exp_seq;
    int found, last_k;
`ifdef ARB_PORT0_PRIORITY_EN
    exp_seq = 4'b0000;
`else
    exp_seq = 4'b1010;
`endif
    do_reset();
    r0_req = 1'b1; r0_write = 1'b0; r0_address = 32'hA0;
    r1_req = 1'b1; r1_write = 1'b0; r1_address = 32'hB0;
    found = 0; last_k = 0;
    for (int k = 1; k <= 60 && found < 4; k++) begin
      @(negedge clock);
      if (a_r0_done || a_r1_done) begin
        n_cmp++; if (a_grant !== exp_seq[found]) begin n_bad++; $display("FAIL contention.grant txn=%0d got %b want %b", found, a_grant, exp_seq[found]); end
        n_cmp++; if (a_r1_done !== exp_seq[found] || a_r0_done === a_r1_done) begin
          n_bad++; $display("FAIL contention.done_port txn=%0d got %b%b want port %0d", found, a_r1_done, a_r0_done, exp_seq[found]); end
        n_cmp++; if ((k - last_k) !== ((found == 0) ? WS + 2 : WS + 3)) begin
          n_bad++; $display("FAIL contention.spacing txn=%0d got %0d want %0d", found, k - last_k, (found == 0) ? WS + 2 : WS + 3); end
        found++; last_k = k;
      end
    end
    n_cmp++; if (found != 4) begin n_bad++; $display("FAIL contention.count got %0d want 4", found); end
    r0_req = 1'b0; r1_req = 1'b0;
  endtask

  task automatic test_isolation();
    do_reset();
    r0_req = 1'b1; r0_write = 1'b0; r0_address = 32'h10; r0_wdata = 64'h77;
    for (int k = 1; k <= WS + 2; k++) begin
      @(negedge clock);
      n_cmp++; if (a_mem_address !== 32'h10 || a_mem_wdata !== 64'h77) begin
        n_bad++; $display("FAIL isolation.bus k=%0d got %0h/%0h want 10/77", k, a_mem_address, a_mem_wdata); end
      if (k == 1) begin r0_address = 32'h99; r0_wdata = 64'hAA; end
      if (k == WS + 2) begin
        n_cmp++; if (a_r0_done !== 1'b1) begin n_bad++; $display("FAIL isolation.done got %b want 1", a_r0_done); end
        r0_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic exp;
    do_reset();
    r1_req = 1'b1; r1_write = 1'b0; r1_address = 32'h30; mem_rdata = 64'hCAFE;
    @(negedge clock);
    @(negedge clock);
    n_cmp++; if (a_mem_read !== 1'b1 || a_grant !== 1'b1) begin n_bad++; $display("FAIL rstmid.pre got rd=%b g=%b want 1/1", a_mem_read, a_grant); end
    reset = 1'b1; r1_req = 1'b0; mem_rdata = 64'hBAD;
    @(negedge clock);
    n_cmp++; if ({a_mem_read, a_mem_write, a_r0_done, a_r1_done} !== 4'b0000) begin
      n_bad++; $display("FAIL rstmid.strobes_done got %b want 0000", {a_mem_read, a_mem_write, a_r0_done, a_r1_done}); end
    n_cmp++; if ({a_busy, a_grant} !== 2'b00) begin n_bad++; $display("FAIL rstmid.busy_grant got %b want 00", {a_busy, a_grant}); end
    n_cmp++; if (a_r1_rdata !== 64'h0) begin n_bad++; $display("FAIL rstmid.rdata got %0h want 0", a_r1_rdata); end
    reset = 1'b0;
    r1_req = 1'b1; r1_address = 32'h31; mem_rdata = 64'hF00D;
    for (int k = 1; k <= WS + 2; k++) begin
      @(negedge clock);
      exp = (k == WS + 2);
      n_cmp++; if (a_r1_done !== exp) begin n_bad++; $display("FAIL rstmid.fresh_done k=%0d got %b want %b", k, a_r1_done, exp); end
    end
    n_cmp++; if (a_r1_rdata !== 64'hF00D) begin n_bad++; $display("FAIL rstmid.fresh_rdata got %0h want f00d", a_r1_rdata); end
    r1_req = 1'b0;
  endtask

  task automatic test_zero_wait();
    logic exp;
    do_reset();
    r0_req = 1'b1; r0_write = 1'b0; r0_address = 32'h40; mem_rdata = 64'h0123_4567_89AB_CDEF;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      exp = (k == 1);
      n_cmp++; if (b_mem_read !== exp) begin n_bad++; $display("FAIL ws0.mem_read k=%0d got %b want %b", k, b_mem_read, exp); end
      exp = (k == 2);
      n_cmp++; if (b_r0_done !== exp) begin n_bad++; $display("FAIL ws0.r0_done k=%0d got %b want %b", k, b_r0_done, exp); end
      if (k == 2) begin
        n_cmp++; if (b_r0_rdata !== 64'h0123_4567_89AB_CDEF) begin n_bad++; $display("FAIL ws0.rdata got %0h want 0123456789abcdef", b_r0_rdata); end
        r0_req = 1'b0;
      end
    end
  endtask

  task automatic test_random();
    @(negedge clock);
    reset = 1'b1; r0_req = 1'b0; r1_req = 1'b0;
    @(posedge clock);
    model_step();
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 600; i++) begin
      n_cmp++; if ({a_mem_read, a_mem_write} !== {exp_rd, exp_wr}) begin
        n_bad++; $display("FAIL rand.strobes i=%0d got %b want %b", i, {a_mem_read, a_mem_write}, {exp_rd, exp_wr}); end
      n_cmp++; if ({a_r0_done, a_r1_done} !== {exp_done0, exp_done1}) begin
        n_bad++; $display("FAIL rand.done i=%0d got %b want %b", i, {a_r0_done, a_r1_done}, {exp_done0, exp_done1}); end
      n_cmp++; if ({a_grant, a_busy} !== {m_owner, exp_busy}) begin
        n_bad++; $display("FAIL rand.grant_busy i=%0d got %b want %b", i, {a_grant, a_busy}, {m_owner, exp_busy}); end
      n_cmp++; if (a_mem_address !== exp_addr || a_mem_wdata !== exp_wdata) begin
        n_bad++; $display("FAIL rand.bus i=%0d got %0h/%0h want %0h/%0h", i, a_mem_address, a_mem_wdata, exp_addr, exp_wdata); end
      n_cmp++; if (a_r0_rdata !== exp_rdata0 || a_r1_rdata !== exp_rdata1) begin
        n_bad++; $display("FAIL rand.rdata i=%0d got %0h/%0h want %0h/%0h", i, a_r0_rdata, a_r1_rdata, exp_rdata0, exp_rdata1); end
      // Requester behaviour: drop after done, otherwise sometimes start a new request
      // or disturb the (already latched) address/data.
      if (r0_req && exp_done0) r0_req = 1'b0;
      else if (!r0_req && $urandom_range(0, 2) == 0) begin
        r0_req = 1'b1; r0_write = 1'($urandom_range(0, 1)); r0_address = $urandom; r0_wdata = {$urandom, $urandom};
      end else if (r0_req && $urandom_range(0, 3) == 0) begin
        r0_address = $urandom; r0_wdata = {$urandom, $urandom};
      end
      if (r1_req && exp_done1) r1_req = 1'b0;
      else if (!r1_req && $urandom_range(0, 2) == 0) begin
        r1_req = 1'b1; r1_write = 1'($urandom_range(0, 1)); r1_address = $urandom; r1_wdata = {$urandom, $urandom};
      end else if (r1_req && $urandom_range(0, 3) == 0) begin
        r1_address = $urandom; r1_wdata = {$urandom, $urandom};
      end
      mem_rdata = {$urandom, $urandom};
      @(posedge clock);
      model_step();
      @(negedge clock);
    end
    r0_req = 1'b0; r1_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_isolation();
    test_reset_mid();
    test_zero_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
